instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
//
// PURPOSE
//   Fetch stage directly upstream of the instruction decoder. Holds the PC and
//   issues 32-bit word reads to instruction memory over a req/ack handshake.
//   Presents {instruction, pc, pc+4} to decode with a valid/ready handshake.
//   Accepts a redirect (taken jump/branch target) from the execute stage.
//
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC fetched first after reset; must be 4-byte aligned
//
// PORTS
//   clk            in   1   clock, rising edge
//   rst_n          in   1   asynchronous reset, active-low
//   imem_req       out  1   read request; held high until imem_ack
//   imem_addr      out  32  word address; stable while imem_req=1
//   imem_ack       in   1   one-cycle pulse, imem_rdata valid this cycle
//   imem_rdata     in   32  fetched instruction word
//   redirect       in   1   jump taken; load redirect_pc as new PC
//   redirect_pc    in   32  jump target
//   instr_valid    out  1   instruction/instr_pc/instr_pc_next valid
//   instr_ready    in   1   decode accepts; transfer when valid&ready
//   instruction    out  32  instruction word to decoder
//   instr_pc       out  32  address of instruction
//   instr_pc_next  out  32  instr_pc + 4 (link value for jal/jalr)
//   misaligned     out  1   sticky fault: redirect_pc[1:0] != 0
//
// BEHAVIOUR
//   Reset (async, immediate):
//   - state=BOOT, imem_req=0, imem_addr=RESET_PC, instr_valid=0,
//     instruction=32'h0000_0013 (nop), instr_pc=RESET_PC,
//     instr_pc_next=RESET_PC+4, misaligned=0, discard=0.
//   - An outstanding memory request is forgotten; imem shares rst_n.
//   - All outputs are registered; no combinational input->output paths.
//   States:
//   - BOOT: next edge -> REQ; imem_req rises 1 cycle after rst_n deasserts.
//   - REQ: imem_req=1.
//     - On ack with discard=0: capture rdata/addr and go HOLD
//       (instr_valid=1 next cycle).
//     - On ack with discard=1: drop data, clear discard, and reissue at the
//       latest pending PC (stay REQ), or go FAULT if a fault is pending.
//   - HOLD: imem_req=0, outputs frozen while instr_ready=0.
//     - On valid&ready: instr_valid=0, imem_addr+=4, go REQ.
//   - FAULT: imem_req=0, instr_valid=0, misaligned=1. Left only by reset.
//   Redirect (priority over all other events):
//   - In REQ before/without ack: addr is held (protocol), discard=1, and the
//     target is stored. A later redirect overwrites it (latest wins).
//   - In REQ on the same cycle as ack: data is dropped, and the next request
//     goes to the target.
//   - In HOLD: instr_valid=0 next cycle; REQ at target.
//     - A valid&ready in that same cycle counts as transferred; decode/execute
//       flush it.
//   - Ignored in FAULT and BOOT.
//   - Misaligned target: misaligned=1 next cycle.
//     - If a request is outstanding, wait for its ack (data discarded), then
//       go to FAULT.
//     - Otherwise go to FAULT directly.
//   Arithmetic and timing:
//   - PC+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000), no flag.
//   - Latency: req->instr_valid = ack latency + 1 cycle.
//   - Zero-wait memory with ready=1: one instruction every 2 cycles.
//
// TESTING
//   1. Reset release, ack same cycle as req, ready=1:
//      -> imem_addr 0,4,8; instr_valid every 2nd cycle with
//      instr_pc 0,4,8, instr_pc_next 4,8,12; first valid at cycle 2.
//   2. instr_ready=0 for 5 cycles while valid:
//      -> instruction/instr_pc stable, imem_req=0; then one transfer and
//      imem_addr+4.
//   3. Redirect to 0x100 in HOLD:
//      -> instr_valid=0 next cycle; next imem_addr=0x100; delivered
//      instr_pc=0x100, instr_pc_next=0x104.
//   4. 3-cycle ack latency, redirect 0x200 then 0x300 during the
//      outstanding request:
//      -> addr held until ack, data never valid, next request 0x300.
//   5. Redirect to 0x102:
//      -> misaligned=1 sticky, no further imem_req, instr_valid=0 until
//      reset.
//   6. rst_n low mid-request, no clock edge:
//      -> outputs at reset values immediately; fetch restarts at RESET_PC.
//   7. PC wrap: redirect to 0xFFFF_FFFC:
//      -> instr_pc_next=0, next fetch addr 0.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction-memory req/ack port, decode valid/ready port and redirect input.
// The master side is the fetch unit; the slave side is the surrounding memory/decode/execute.
interface instruction_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_next;
    logic        misaligned;

    modport master (
        output imem_req, imem_addr, instr_valid, instruction, instr_pc, instr_pc_next,
               misaligned,
        input  imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instruction, instr_pc, instr_pc_next,
               misaligned,
        output imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, reads instruction words over req/ack and hands
// {instruction, pc, pc+4} to decode over valid/ready; accepts execute redirects.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                  clk,
    input logic                  rst_n,
    instruction_fetch_if.master  bus
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {StBoot, StReq, StHold, StFault} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] target_q, target_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_next_q, pc_next_d;
    logic        valid_q, valid_d;
    logic        discard_q, discard_d;
    logic        fault_pend_q, fault_pend_d;
    logic        mis_q, mis_d;
    logic        redir_bad;

    assign redir_bad = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StBoot;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        target_d     = target_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        pc_next_d    = pc_next_q;
        valid_d      = valid_q;
        discard_d    = discard_q;
        fault_pend_d = fault_pend_q;
        mis_d        = mis_q;
        unique case (state_q)
            StBoot: state_d = StReq;
            StReq: begin
                if (bus.redirect) begin
                    if (redir_bad) mis_d = 1'b1;
                    if (bus.imem_ack) begin
                        // Request completes this cycle; its data is dropped.
                        discard_d = 1'b0;
                        if (redir_bad || fault_pend_q) state_d = StFault;
                        else                           addr_d  = bus.redirect_pc;
                    end else begin
                        // Address must stay put until ack; remember where to go.
                        discard_d = 1'b1;
                        if (redir_bad) fault_pend_d = 1'b1;
                        else           target_d     = bus.redirect_pc;
                    end
                end else if (bus.imem_ack) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        if (fault_pend_q) state_d = StFault;
                        else              addr_d  = target_q;
                    end else begin
                        instr_d   = bus.imem_rdata;
                        pc_d      = addr_q;
                        pc_next_d = addr_q + 32'd4;
                        valid_d   = 1'b1;
                        state_d   = StHold;
                    end
                end
            end
            StHold: begin
                if (bus.redirect) begin
                    valid_d = 1'b0;
                    if (redir_bad) begin
                        mis_d   = 1'b1;
                        state_d = StFault;
                    end else begin
                        addr_d  = bus.redirect_pc;
                        state_d = StReq;
                    end
                end else if (bus.instr_ready) begin
                    valid_d = 1'b0;
                    addr_d  = addr_q + 32'd4;
                    state_d = StReq;
                end
            end
            StFault: valid_d = 1'b0;
            default: state_d = StBoot;
        endcase
    end

    always_comb begin
        bus.imem_req      = (state_q == StReq);
        bus.imem_addr     = addr_q;
        bus.instr_valid   = valid_q;
        bus.instruction   = instr_q;
        bus.instr_pc      = pc_q;
        bus.instr_pc_next = pc_next_q;
        bus.misaligned    = mis_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= RESET_PC;
            target_q     <= RESET_PC;
            instr_q      <= NOP;
            pc_q         <= RESET_PC;
            pc_next_q    <= RESET_PC + 32'd4;
            valid_q      <= 1'b0;
            discard_q    <= 1'b0;
            fault_pend_q <= 1'b0;
            mis_q        <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            target_q     <= target_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            pc_next_q    <= pc_next_d;
            valid_q      <= valid_d;
            discard_q    <= discard_d;
            fault_pend_q <= fault_pend_d;
            mis_q        <= mis_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus a randomized run against a
// program-order scoreboard and a latency-randomized memory responder.
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instruction_fetch_if bus ();

    instruction_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int          checks = 0;
    int          errors = 0;
    int          lat_lo = 0;
    int          lat_hi = 0;
    int          cnt = 0;
    int          transfers = 0;
    bit          busy = 1'b0;
    bit          faulted = 1'b0;
    logic [31:0] raddr = '0;
    logic [31:0] exp_pc = RESET_PC;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        busy          = 1'b0;
        cnt           = 0;
        faulted       = 1'b0;
        exp_pc        = RESET_PC;
        bus.imem_ack  = 1'b0;
        bus.instr_ready = 1'b0;
        bus.redirect  = 1'b0;
        bus.redirect_pc = '0;
    endtask

    // One clock: drive this cycle's inputs, answer memory, score transfers.
    task automatic cycle(input bit rdy, input bit redir, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        bus.instr_ready = rdy;
        bus.redirect    = redir;
        bus.redirect_pc = tgt;
        bus.imem_ack    = 1'b0;
        if (busy) begin
            check("req_hold", 32'(bus.imem_req), 1);
            check("addr_hold", bus.imem_addr, raddr);
        end
        if (bus.imem_req) begin
            if (!busy) begin
                busy  = 1'b1;
                raddr = bus.imem_addr;
                cnt   = int'($urandom_range(lat_hi, lat_lo));
            end
            if (cnt == 0) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = mem_word(raddr);
                busy           = 1'b0;
            end else begin
                cnt--;
            end
        end
        if (faulted) begin
            check("fault_novalid", 32'(bus.instr_valid), 0);
            check("fault_sticky", 32'(bus.misaligned), 1);
        end else if (bus.instr_valid && rdy) begin
            check("sb_pc", bus.instr_pc, exp_pc);
            check("sb_pc_next", bus.instr_pc_next, exp_pc + 32'd4);
            check("sb_instr", bus.instruction, mem_word(exp_pc));
            transfers++;
            exp_pc = exp_pc + 32'd4;
        end
        if (redir && !faulted) begin
            if (tgt[1:0] != 2'b00) faulted = 1'b1;
            else                   exp_pc  = tgt;
        end
    endtask

    task automatic wait_valid(input int limit);
        for (int i = 0; i < limit; i++) begin
            cycle(1'b0, 1'b0, '0);
            if (bus.instr_valid) break;
        end
        check("wait_valid", 32'(bus.instr_valid), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] tgt;
        bit          rdy;
        bit          redir;

        model_reset();
        bus.imem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.instr_valid), 0);
        check("rst_instr", bus.instruction, 32'h0000_0013);
        check("rst_pc_next", bus.instr_pc_next, RESET_PC + 32'd4);
        rst_n = 1'b1;
        check("boot_req", 32'(bus.imem_req), 0);

        // Zero-wait memory, decode always ready.
        lat_lo = 0;
        lat_hi = 0;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b0, '0);
            check("t1_req", 32'(bus.imem_req), 1);
            check("t1_addr", bus.imem_addr, 32'(4 * k));
            cycle(1'b1, 1'b0, '0);
            check("t1_valid", 32'(bus.instr_valid), 1);
            check("t1_pc", bus.instr_pc, 32'(4 * k));
            check("t1_pc_next", bus.instr_pc_next, 32'(4 * k + 4));
        end

        // Decode stalls for five cycles.
        cycle(1'b1, 1'b0, '0);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b0, '0);
            check("t2_valid", 32'(bus.instr_valid), 1);
            check("t2_pc", bus.instr_pc, 32'd12);
            check("t2_instr", bus.instruction, mem_word(32'd12));
            check("t2_req", 32'(bus.imem_req), 0);
        end
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        check("t2_next_addr", bus.imem_addr, 32'd16);

        // Redirect while holding an instruction.
        cycle(1'b0, 1'b1, 32'h100);
        check("t3_hold_pc", bus.instr_pc, 32'd16);
        cycle(1'b1, 1'b0, '0);
        check("t3_valid_drop", 32'(bus.instr_valid), 0);
        check("t3_addr", bus.imem_addr, 32'h100);
        cycle(1'b1, 1'b0, '0);
        check("t3_pc", bus.instr_pc, 32'h100);
        check("t3_pc_next", bus.instr_pc_next, 32'h104);

        // Two redirects during a slow outstanding request.
        lat_lo = 3;
        lat_hi = 3;
        cycle(1'b1, 1'b1, 32'h200);
        check("t4_addr0", bus.imem_addr, 32'h104);
        cycle(1'b1, 1'b1, 32'h300);
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1, 1'b0, '0);
            check("t4_addr_held", bus.imem_addr, 32'h104);
            check("t4_novalid", 32'(bus.instr_valid), 0);
        end
        cycle(1'b1, 1'b0, '0);
        check("t4_new_addr", bus.imem_addr, 32'h300);
        check("t4_discarded", 32'(bus.instr_valid), 0);
        wait_valid(10);
        check("t4_pc", bus.instr_pc, 32'h300);
        cycle(1'b1, 1'b0, '0);

        // PC wrap at the top of the address space.
        lat_lo = 0;
        lat_hi = 0;
        wait_valid(10);
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
        wait_valid(10);
        check("t7_pc", bus.instr_pc, 32'hFFFF_FFFC);
        check("t7_pc_next", bus.instr_pc_next, 32'h0000_0000);
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        check("t7_req", 32'(bus.imem_req), 1);
        check("t7_addr", bus.imem_addr, 32'h0000_0000);

        // Asynchronous reset in the middle of an outstanding request.
        lat_lo = 3;
        lat_hi = 3;
        cycle(1'b0, 1'b0, '0);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_req", 32'(bus.imem_req), 0);
        check("t6_valid", 32'(bus.instr_valid), 0);
        check("t6_addr", bus.imem_addr, RESET_PC);
        check("t6_instr", bus.instruction, 32'h0000_0013);
        check("t6_pc", bus.instr_pc, RESET_PC);
        check("t6_pc_next", bus.instr_pc_next, RESET_PC + 32'd4);
        check("t6_mis", 32'(bus.misaligned), 0);
        @(posedge clk);
        #1;
        model_reset();
        rst_n  = 1'b1;
        lat_lo = 0;
        lat_hi = 0;
        wait_valid(10);
        check("t6_restart_pc", bus.instr_pc, RESET_PC);
        cycle(1'b1, 1'b0, '0);

        // Misaligned target while a request is outstanding.
        lat_lo = 3;
        lat_hi = 3;
        cycle(1'b1, 1'b1, 32'h102);
        check("t5_addr", bus.imem_addr, 32'd4);
        cycle(1'b1, 1'b0, '0);
        check("t5_mis", 32'(bus.misaligned), 1);
        check("t5_req_pending", 32'(bus.imem_req), 1);
        repeat (8) cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 32'h40);
        repeat (4) cycle(1'b1, 1'b0, '0);
        check("t5_req_off", 32'(bus.imem_req), 0);
        check("t5_valid_off", 32'(bus.instr_valid), 0);

        // Randomized run: random latency, ready and aligned redirects.
        do_reset();
        lat_lo    = 0;
        lat_hi    = 3;
        transfers = 0;
        for (int n = 0; n < 3000; n++) begin
            rdy   = ($urandom_range(9, 0) < 7);
            redir = ($urandom_range(19, 0) == 0);
            tgt   = ($urandom() & 32'h0000_3FFC) | 32'h0001_0000;
            cycle(rdy, redir, tgt);
        end
        check("progress", 32'(transfers > 200), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
